// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - iterative multiply/divide unit with HI/LO registers
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     a, b;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic                 op_div, sx, sy, dz_pend;

    logic                 x_neg, y_neg, y_zero;
    logic [WIDTH-1:0]     x_mag, y_mag;
    logic [WIDTH:0]       mul_sum, div_trial, div_diff;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     res_hi, res_lo;

    // Unsigned ops (op[0]=1) never look at sign bits, so their sign flags stay 0.
    assign x_neg  = ~op[0] & x[WIDTH-1];
    assign y_neg  = ~op[0] & y[WIDTH-1];
    assign x_mag  = x_neg ? -x : x;
    assign y_mag  = y_neg ? -y : y;
    assign y_zero = (y == '0);

    assign busy = (state != IDLE);

    // acc is {partial product, shifted-out low bits} for multiply and
    // {remainder, quotient} for divide; the dividend shifts out of a.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (b[0] ? a : '0)};
    assign div_trial = {acc[2*WIDTH-1:WIDTH], a[WIDTH-1]};
    assign div_diff  = div_trial - {1'b0, b};
    assign div_ge    = ~div_diff[WIDTH];
    assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];

    always_comb begin
        prod   = (sx ^ sy) ? -acc : acc;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (op_div) begin
            res_lo = (sx ^ sy) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            res_hi = sx ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && !op[2]) state_nxt = (op[1] && y_zero) ? FIX : CALC;
            CALC: if (cnt == LAST) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a       <= '0;
            b       <= '0;
            acc     <= '0;
            cnt     <= '0;
            op_div  <= 1'b0;
            sx      <= 1'b0;
            sy      <= 1'b0;
            dz_pend <= 1'b0;
            done    <= 1'b0;
            dz      <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            dz   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !op[2]) begin
                        a       <= x_mag;
                        b       <= y_mag;
                        op_div  <= op[1];
                        sx      <= x_neg;
                        sy      <= y_neg;
                        acc     <= '0;
                        cnt     <= '0;
                        dz_pend <= op[1] && y_zero;
                    end else if (start && !op[1]) begin
                        if (op[0]) lo <= x;
                        else       hi <= x;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op_div) begin
                        acc <= {div_rem, acc[WIDTH-2:0], div_ge};
                        a   <= a << 1;
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                        b   <= b >> 1;
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    dz   <= dz_pend;
                    if (!dz_pend) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - randomized bench for hilo_muldiv against an arithmetic model
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b111;
    logic [31:0] x = '0, y = '0;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    int tests = 0, fails = 0;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .x(x), .y(y),
        .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: result computed with plain 64-bit arithmetic at accept time,
    // then released after the documented latency.
    logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
    int          m_left = 0;
    bit          m_done = 0, m_dz = 0, m_dzp = 0;

    task automatic compute(input logic [2:0] o, input logic [31:0] a, input logic [31:0] bb);
        longint      sa, sb, p, q, r;
        logic [63:0] pu;
        sa = $signed(a);
        sb = $signed(bb);
        m_dzp = o[1] && (bb == 0);
        r_hi = '0;
        r_lo = '0;
        case (o[1:0])
            2'b00: begin p = sa * sb; r_hi = p[63:32]; r_lo = p[31:0]; end
            2'b01: begin pu = {32'b0, a} * {32'b0, bb}; r_hi = pu[63:32]; r_lo = pu[31:0]; end
            2'b10: if (!m_dzp) begin q = sa / sb; r = sa % sb; r_lo = q[31:0]; r_hi = r[31:0]; end
            default: if (!m_dzp) begin r_lo = a / bb; r_hi = a % bb; end
        endcase
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_done = 0; m_dz = 0;
        end else begin
            m_done = 0;
            m_dz   = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1;
                    m_dz   = m_dzp;
                    if (!m_dzp) begin m_hi = r_hi; m_lo = r_lo; end
                end
            end else if (start && !op[2]) begin
                compute(op, x, y);
                m_left = m_dzp ? 1 : 33;
            end else if (start && op == 3'b100) begin
                m_hi = x;
            end else if (start && op == 3'b101) begin
                m_lo = x;
            end
        end
        #3;
        chk("busy", busy, m_left > 0);
        chk("done", done, m_done);
        chk("dz",   dz,   m_dz);
        chk("hi",   hi,   m_hi);
        chk("lo",   lo,   m_lo);
    end

    int bcnt, dcnt;
    bit dzs;

    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] bb);
        @(negedge clk);
        start = 1'b1; op = o; x = a; y = bb;
        @(negedge clk);
        start = 1'b0;
        bcnt = 0; dcnt = 0; dzs = 0;
        for (int i = 0; i < 60; i++) begin
            if (busy) bcnt++;
            if (done) begin dcnt++; dzs = dz; end
            if (!busy) break;
            @(negedge clk);
        end
        chk("timeout", busy, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        rst = 1'b0;

        run(3'b000, 32'd7, 32'hFFFF_FFFD);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);
        chk("mult_busy_cycles", bcnt, 33);
        chk("mult_done_pulses", dcnt, 1);

        run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        run(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mult_m1_hi", hi, 32'h0);
        chk("mult_m1_lo", lo, 32'h1);

        run(3'b010, 32'hFFFF_FFF9, 32'd2);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        run(3'b011, 32'hFFFF_FFF9, 32'd2);
        chk("divu_lo", lo, 32'h7FFF_FFFC);
        chk("divu_hi", hi, 32'h1);
        run(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'h0);

        run(3'b100, 32'h1234, 32'h0);
        run(3'b101, 32'h5678, 32'h0);
        run(3'b010, 32'd5, 32'h0);
        chk("dz_busy_cycles", bcnt, 1);
        chk("dz_done", dcnt, 1);
        chk("dz_flag", dzs, 1'b1);
        chk("dz_hi", hi, 32'h1234);
        chk("dz_lo", lo, 32'h5678);

        @(negedge clk);
        start = 1'b1; op = 3'b000; x = 32'd100; y = 32'hFFFF_FFFD;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; op = 3'b101; x = 32'hDEAD; y = $urandom;
        @(negedge clk);
        start = 1'b0; x = $urandom; y = $urandom;
        for (int i = 0; i < 60 && busy; i++) @(negedge clk);
        chk("inflight_timeout", busy, 1'b0);
        chk("inflight_hi", hi, 32'hFFFF_FFFF);
        chk("inflight_lo", lo, 32'hFFFF_FED4);

        @(negedge clk);
        start = 1'b1; op = 3'b010; x = 32'd1000; y = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        chk("abort_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run(3'b001, 32'd3, 32'd4);
        chk("after_abort_lo", lo, 32'd12);
        chk("after_abort_hi", hi, 32'd0);
        chk("after_abort_done", dcnt, 1);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst   = ($urandom % 700 == 0);
            start = ($urandom % 4 == 0);
            op    = 3'($urandom % 8);
            x     = pick();
            y     = ($urandom % 8 == 0) ? 32'h0 : pick();
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
